// File: rtl/mdu_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package mdu_pkg;
  localparam int          ITER    = 32;
  localparam logic [31:0] DIV0_LO = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MSUB  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction
endpackage

// File: rtl/mdu_sign_fix.sv
// Operand magnitude extraction and result negation for the multiply/divide unit.
module mdu_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sgn,
  output logic [WIDTH-1:0] o_mag_a,
  output logic [WIDTH-1:0] o_mag_b,
  output logic             o_neg_a,
  output logic             o_neg_b,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic             i_wide,
  input  logic             i_neg_hi,
  input  logic             i_neg_lo,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  logic [2*WIDTH-1:0] w_neg_wide;

  // -2^(W-1) negates to itself, which is exactly its unsigned magnitude
  assign o_neg_a    = i_sgn & i_a[WIDTH-1];
  assign o_neg_b    = i_sgn & i_b[WIDTH-1];
  assign o_mag_a    = o_neg_a ? -i_a : i_a;
  assign o_mag_b    = o_neg_b ? -i_b : i_b;
  assign w_neg_wide = -{i_hi, i_lo};

  always_comb begin
    o_hi = i_hi;
    o_lo = i_lo;
    if (i_wide) begin
      if (i_neg_hi) {o_hi, o_lo} = w_neg_wide;
    end else begin
      if (i_neg_hi) o_hi = -i_hi;
      if (i_neg_lo) o_lo = -i_lo;
    end
  end
endmodule

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit feeding the HI/LO register pair.
// Fixed 34-edge latency: E0 accept, E1..E32 iterate, E33 sign fix, E34 HI/LO capture.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_hi_cur,
  input  logic [WIDTH-1:0] i_lo_cur,
  input  logic             i_cancel,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi_out,
  output logic [WIDTH-1:0] o_lo_out,
  output logic             o_hi_write,
  output logic             o_lo_write
);
  import mdu_pkg::*;

  localparam int CNT_W = $clog2(ITER);

  state_e             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  op_e                r_op;
  logic [WIDTH-1:0]   r_a, r_dv, r_hc, r_lc, r_hi_res, r_lo_res;
  logic               r_neg_q, r_neg_r, r_b_zero;
  logic [2*WIDTH-1:0] r_sr;

  op_e                w_op;
  logic               w_accept, w_is_div;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_fix_hi, w_fix_lo;
  logic               w_neg_a, w_neg_b;
  logic [WIDTH:0]     w_madd, w_rem_sh;
  logic [WIDTH-1:0]   w_sub;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_mul_nx, w_div_nx, w_prod, w_res;

  assign w_op     = op_e'(i_op);
  assign w_accept = i_start && (i_op <= OP_MSUB) && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_is_div = op_is_div(r_op);

  mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .i_a      (i_a),
    .i_b      (i_b),
    .i_sgn    (op_is_signed(w_op)),
    .o_mag_a  (w_mag_a),
    .o_mag_b  (w_mag_b),
    .o_neg_a  (w_neg_a),
    .o_neg_b  (w_neg_b),
    .i_hi     (r_sr[2*WIDTH-1:WIDTH]),
    .i_lo     (r_sr[WIDTH-1:0]),
    .i_wide   (!w_is_div),
    .i_neg_hi (w_is_div ? r_neg_r : r_neg_q),
    .i_neg_lo (r_neg_q),
    .o_hi     (w_fix_hi),
    .o_lo     (w_fix_lo)
  );

  // Multiply: {partial, multiplier} shifts right, carry drops into the top bit.
  assign w_madd   = {1'b0, r_sr[2*WIDTH-1:WIDTH]} + (r_sr[0] ? {1'b0, r_dv} : '0);
  assign w_mul_nx = {w_madd, r_sr[WIDTH-1:1]};

  // Divide: {remainder, dividend/quotient} shifts left; restoring compare.
  assign w_rem_sh = r_sr[2*WIDTH-1:WIDTH-1];
  assign w_ge     = w_rem_sh >= {1'b0, r_dv};
  assign w_sub    = w_rem_sh[WIDTH-1:0] - r_dv;
  assign w_div_nx = w_ge ? {w_sub, r_sr[WIDTH-2:0], 1'b1} : {r_sr[2*WIDTH-2:0], 1'b0};

  assign w_prod = {w_fix_hi, w_fix_lo};

  always_comb begin
    w_res = w_prod;
    case (r_op)
      OP_MADD: w_res = {r_hc, r_lc} + w_prod;
      OP_MSUB: w_res = {r_hc, r_lc} - w_prod;
      OP_DIV, OP_DIVU: if (r_b_zero) w_res = {r_a, WIDTH'(DIV0_LO)};
      default: w_res = w_prod;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_RUN;
      S_RUN: begin
        if (i_cancel)                          w_next = S_IDLE;
        else if (r_cnt == CNT_W'(ITER - 1))    w_next = S_FIX;
      end
      S_FIX:  w_next = i_cancel ? S_IDLE : S_DONE;
      S_DONE: w_next = w_accept ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy     = 1'b0;
    o_done     = 1'b0;
    o_hi_write = 1'b0;
    o_lo_write = 1'b0;
    case (r_state)
      S_RUN, S_FIX: o_busy = 1'b1;
      S_DONE: begin
        o_done     = 1'b1;
        o_hi_write = 1'b1;
        o_lo_write = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_op     <= OP_MULT;
      r_a      <= '0;
      r_dv     <= '0;
      r_hc     <= '0;
      r_lc     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_b_zero <= 1'b0;
      r_sr     <= '0;
      r_hi_res <= '0;
      r_lo_res <= '0;
    end else begin
      if (w_accept) begin
        r_cnt    <= '0;
        r_op     <= w_op;
        r_a      <= i_a;
        r_hc     <= i_hi_cur;
        r_lc     <= i_lo_cur;
        r_neg_q  <= w_neg_a ^ w_neg_b;
        r_neg_r  <= w_neg_a;
        r_b_zero <= (i_b == '0);
        r_dv     <= op_is_div(w_op) ? w_mag_b : w_mag_a;
        r_sr     <= {{WIDTH{1'b0}}, (op_is_div(w_op) ? w_mag_a : w_mag_b)};
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_sr  <= w_is_div ? w_div_nx : w_mul_nx;
      end
      // Result registers only change on a completed op, so they hold across cancel.
      if ((r_state == S_FIX) && !i_cancel) begin
        r_hi_res <= w_res[2*WIDTH-1:WIDTH];
        r_lo_res <= w_res[WIDTH-1:0];
      end
    end
  end

  assign o_hi_out = r_hi_res;
  assign o_lo_out = r_lo_res;
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: cycle-level reference model plus directed vectors.
module tb_mul_div_unit;
  logic        clk, rst_n, start, cancel;
  logic [2:0]  op;
  logic [31:0] a, b, hc, lc;
  logic        busy, done, hi_wr, lo_wr;
  logic [31:0] hi_out, lo_out;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  // reference model state: edges since accept (-1 = nothing in flight)
  int          age = -1;
  logic [63:0] pend = '0;
  logic [63:0] exp_res = '0;

  mul_div_unit #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op), .i_a(a), .i_b(b),
    .i_hi_cur(hc), .i_lo_cur(lc), .i_cancel(cancel), .o_busy(busy), .o_done(done),
    .o_hi_out(hi_out), .o_lo_out(lo_out), .o_hi_write(hi_wr), .o_lo_write(lo_wr)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, y, h, l);
    int sx, sy, q, m;
    longint p;
    logic [63:0] ux, uy, r;
    sx = x; sy = y;
    ux = {32'b0, x}; uy = {32'b0, y};
    p  = longint'(sx) * longint'(sy);
    r  = '0;
    case (o)
      3'd0: r = p;
      3'd1: r = ux * uy;
      3'd2: begin
        if (y == 0) r = {x, 32'hFFFFFFFF};
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = {32'h0, 32'h80000000};
        else begin q = sx / sy; m = sx % sy; r = {m, q}; end
      end
      3'd3: begin
        if (y == 0) r = {x, 32'hFFFFFFFF};
        else r = {x % y, x / y};
      end
      3'd4: r = {h, l} + p;
      3'd5: r = {h, l} - p;
      default: r = '0;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      age = -1;
      exp_res = '0;
    end else begin
      if (age >= 0 && age <= 32) age = cancel ? -1 : age + 1;
      else if (start && op <= 3'd5) begin
        age  = 0;
        pend = model(op, a, b, hc, lc);
      end else age = -1;
      if (age == 33) exp_res = pend;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic eb, ed;
      eb = (age >= 0 && age <= 32);
      ed = (age == 33);
      n_tests++;
      if (busy !== eb || done !== ed || hi_wr !== ed || lo_wr !== ed ||
          hi_out !== exp_res[63:32] || lo_out !== exp_res[31:0]) begin
        n_fail++;
        $display("FAIL cycle t=%0t busy=%b/%b done=%b/%b wr=%b%b/%b hi=%h/%h lo=%h/%h (got/exp)",
                 $time, busy, eb, done, ed, hi_wr, lo_wr, ed, hi_out, exp_res[63:32],
                 lo_out, exp_res[31:0]);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // called at a negedge; returns at the negedge after the accept edge
  task automatic issue(input logic [2:0] o, input logic [31:0] x, y, h, l);
    op = o; a = x; b = y; hc = h; lc = l; start = 1;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    hc = 32'hDEADBEEF; lc = 32'h0BADF00D;
    a  = 32'h5A5A5A5A; b  = 32'hA5A5A5A5;
  endtask

  task automatic wait_write(output int n);
    n = 0;
    while (!hi_wr && n < 60) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_lit(input string name, input logic [2:0] o, input logic [31:0] x, y, h, l,
                         input logic [31:0] eh, input logic [31:0] el);
    int n;
    check({name, "_model"}, model(o, x, y, h, l), {eh, el});
    issue(o, x, y, h, l);
    wait_write(n);
    check({name, "_latency"}, 64'(n + 1), 64'd34);
    check({name, "_res"}, {hi_out, lo_out}, {eh, el});
    @(negedge clk);
  endtask

  task automatic count_writes(input int cycles, output int w);
    w = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (hi_wr || lo_wr) w++;
    end
  endtask

  initial begin
    int n, w;
    rst_n = 0; start = 0; cancel = 0; op = 0; a = 0; b = 0; hc = 0; lc = 0;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1;
    @(negedge clk);
    check("reset_outs", {busy, done, hi_wr, lo_wr, hi_out, lo_out}, '0);
    rst_n = 1;
    @(negedge clk);

    run_lit("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFE, 32'h00000001);
    run_lit("mult_neg",  3'd0, -32'sd3, 32'd7, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_lit("mult_min",  3'd0, 32'h80000000, 32'h80000000, 0, 0, 32'h40000000, 32'h0);
    run_lit("div_neg",   3'd2, -32'sd7, 32'd2, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_lit("div_negb",  3'd2, 32'd7, -32'sd2, 0, 0, 32'h1, 32'hFFFFFFFD);
    run_lit("divu",      3'd3, 32'd100, 32'd7, 0, 0, 32'd2, 32'd14);
    run_lit("div_zero",  3'd2, 32'h1234, 32'd0, 0, 0, 32'h1234, 32'hFFFFFFFF);
    run_lit("divu_zero", 3'd3, 32'hF0000005, 32'd0, 0, 0, 32'hF0000005, 32'hFFFFFFFF);
    run_lit("div_ovf",   3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0, 32'h0, 32'h80000000);
    run_lit("madd",      3'd4, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h0);
    run_lit("msub",      3'd5, 32'd1, 32'd1, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_lit("msub_neg",  3'd5, -32'sd2, 32'd3, 32'h0, 32'h10, 32'h0, 32'h16);

    // start while busy is ignored
    issue(3'd1, 32'd3, 32'd5, 0, 0);
    repeat (5) @(negedge clk);
    op = 3'd3; a = 32'd9; b = 32'd2; start = 1;
    @(negedge clk);
    start = 0;
    wait_write(n);
    check("busy_start_res", {hi_out, lo_out}, {32'd0, 32'd15});
    check("busy_start_lat", 64'(n + 6 + 1), 64'd34);
    @(negedge clk);

    // cancel taken at E10
    issue(3'd0, 32'd11, 32'd13, 0, 0);
    repeat (9) @(negedge clk);
    cancel = 1;
    @(negedge clk);
    cancel = 0;
    check("cancel_busy", 64'(busy), 64'd0);
    count_writes(40, w);
    check("cancel_nowrite", 64'(w), 64'd0);
    check("cancel_hold", {hi_out, lo_out}, {32'd0, 32'd15});

    // reserved op ignored; cancel with start in IDLE lets start win
    op = 3'd6; start = 1;
    @(negedge clk);
    start = 0;
    check("reserved_busy", 64'(busy), 64'd0);
    cancel = 1;
    issue(3'd1, 32'd2, 32'd21, 0, 0);
    cancel = 0;
    check("cancel_start_busy", 64'(busy), 64'd1);
    wait_write(n);
    check("cancel_start_res", {hi_out, lo_out}, {32'd0, 32'd42});
    @(negedge clk);

    // reset at E20 discards the op
    issue(3'd1, 32'd1000, 32'd1000, 0, 0);
    repeat (19) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    check("midreset_outs", {busy, done, hi_wr, lo_wr, hi_out, lo_out}, '0);
    rst_n = 1;
    count_writes(40, w);
    check("midreset_nowrite", 64'(w), 64'd0);

    // start in DONE cycle is accepted; cancel there has no effect
    issue(3'd3, 32'd100, 32'd7, 0, 0);
    wait_write(n);
    check("b2b_first", {hi_out, lo_out}, {32'd2, 32'd14});
    cancel = 1;
    issue(3'd1, 32'd6, 32'd7, 0, 0);
    cancel = 0;
    check("b2b_busy", 64'(busy), 64'd1);
    wait_write(n);
    check("b2b_latency", 64'(n + 1), 64'd34);
    check("b2b_second", {hi_out, lo_out}, {32'd0, 32'd42});

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
